psimd_issue_ctrl: RTL and testbench
===================================

# psimd_issue_ctrl

Issue sequencer for the PSIMD DLFloat16 unit. Accepts one 32-bit PSIMD instruction at a time from the scalar core over a valid/ready handshake. Sequences register-file read, Execution_unit start/completion and register-file write-back. Collapses the four per-lane exception vectors into a 5-bit flag word. Sits between the core and the decoder / psimd_reg_file / Execution_unit group.

## Interface
Parameters:
- EXEC_TIMEOUT, 31: maximum WAIT cycles for a multi-cycle op before abort; 1..255.
- CNT_W, 8: width of the WAIT counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  core presents instruction.
- instr  in  32  instruction word; sampled when instr_valid & instr_ready.
- instr_ready  out  1  controller idle; high only in IDLE.
- dec_multi  in  1  decoder: op is multi-cycle (div/sqrt).
- dec_wr  in  1  decoder: op writes rd.
- dec_illegal  in  1  decoder: instruction not PSIMD-legal.
- dec_rd  in  5  decoder: destination address.
- instr_q  out  32  latched instruction, drives decoder during the op.
- rf_rd_en  out  1  register-file read strobe.
- eu_start  out  1  one-cycle start pulse to the execution unit.
- eu_done  in  1  multi-cycle op result valid.
- invalid, inexact, overflow, underflow, div_by_zero  in  4 each  per-lane flags from the execution unit.
- rf_wr_en  out  1  write-back strobe.
- rf_wr_addr  out  5  write-back address.
- fflags  out  5  {invalid, div_by_zero, overflow, underflow, inexact}.
- fflags_clr  in  1  clear flag word.
- done  out  1  one-cycle completion pulse.
- err_illegal  out  1  one-cycle pulse, illegal instruction dropped.
- err_timeout  out  1  one-cycle pulse, multi-cycle op aborted.

## Operation
States: IDLE, READ, EXEC, WAIT, WB.
- IDLE: instr_ready=1. On handshake, latch instr_q. Next state is READ.
- READ: rf_rd_en=1. If dec_illegal, pulse err_illegal and return to IDLE with no read or write. Otherwise latch dec_multi, dec_wr and dec_rd, then go to EXEC.
- EXEC: eu_start=1. If the latched multi bit is clear, capture the flags this cycle and go to WB. If it is set, clear the counter and go to WAIT.
- WAIT: counter increments each cycle.
  - eu_done: capture flags, go to WB.
  - Otherwise, when the counter reaches EXEC_TIMEOUT: pulse err_timeout, return to IDLE with no write and no flag update.
  - eu_done in the timeout cycle: eu_done wins.
- WB: rf_wr_en = latched dec_wr; rf_wr_addr = latched rd; done=1; fflags updated. Next state is IDLE.
- Flag capture: each flag bit is the OR of its four lane bits, registered at capture.
- fflags update: next = (fflags_clr ? 0 : fflags) | captured. A clear and a new flag in the same cycle leaves the new flag set.
- fflags_clr outside WB clears immediately.
- rst in any state: state=IDLE, counter=0, instr_q=0, fflags=0.
  - All strobes and pulses are 0 in the same edge.
  - An in-flight op is discarded with no write-back.
- eu_done outside WAIT is ignored.

## Timing
- Reset values: instr_ready=1 (IDLE), every other output 0.
- Single-cycle op, handshake at edge 0:
  - READ in cycle 1, EXEC in cycle 2.
  - rf_wr_en and done in cycle 3.
  - instr_ready high again in cycle 4.
- Throughput is one op per 4 cycles.
- Multi-cycle op: if eu_done arrives k cycles after WAIT entry, WB occurs k+1 cycles later.
- Illegal op: err_illegal in cycle 1, instr_ready in cycle 2.
- Timeout: err_timeout is asserted in the cycle the counter equals EXEC_TIMEOUT. instr_ready rises the next cycle.
- instr_valid with instr_ready=0 is ignored. The core must hold the instruction until accepted.

## Configuration
- PSIMD_ISSUE_STICKY_FFLAGS_EN defined: fflags accumulates across instructions as above, until fflags_clr or rst.
- Not defined:
  - fflags is overwritten at each WB with that instruction's captured flags only (no OR with the previous value).
  - fflags_clr is ignored.
  - Timeout and illegal paths do not alter fflags.

## Structure
- psimd_pkg holds:
  - the issue_state_t enum (IDLE, READ, EXEC, WAIT, WB);
  - the FFLAG_NV/DZ/OF/UF/NX bit-index constants;
  - the default EXEC_TIMEOUT.
- One sub-module, psimd_flag_acc: lane reduction, capture register and sticky/overwrite logic. This is where the macro lives.

## Test plan
- Reset, then single-cycle op with dec_wr=1, dec_rd=5'd7, handshake at cycle 0 -> rf_wr_en=1, rf_wr_addr=7, done=1 in cycle 3 only; instr_ready=1 in cycle 4.
- Multi-cycle op, eu_done 6 cycles after WAIT entry, inexact=4'b0010 -> WB one cycle later, fflags=5'b00001.
- Multi-cycle op with eu_done never asserted, EXEC_TIMEOUT=31 -> err_timeout at WAIT count 31, no rf_wr_en, fflags unchanged.
- dec_illegal=1 -> err_illegal pulse in cycle 1, no rf_rd_en, no rf_wr_en, instr_ready back in cycle 2.
- Sticky build:
  - overflow op, then fflags_clr coincident with a WB carrying invalid -> fflags=5'b10000.
  - A further inexact op -> fflags=5'b10001.
  - Non-sticky build, same sequence -> fflags=5'b00001.
- rst asserted during WAIT -> next cycle: IDLE, instr_ready=1, all other outputs 0, later eu_done ignored.

Source files
------------

// File: rtl/psimd_pkg.sv
// Shared types and constants for the PSIMD issue controller.
// Issue states, fflags bit positions, default multi-cycle timeout and the lane-reduction helper.
package psimd_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    EXEC = 3'd2,
    WAIT = 3'd3,
    WB   = 3'd4
  } issue_state_t;

  localparam int FFLAG_W  = 5;
  localparam int FFLAG_NV = 4;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_NX = 0;

  localparam int EXEC_TIMEOUT_DEF = 31;

  // A flag is raised when any of the four lanes raised it.
  function automatic logic [FFLAG_W-1:0] lane_reduce(
    input logic [3:0] nv,
    input logic [3:0] dz,
    input logic [3:0] ov,
    input logic [3:0] uf,
    input logic [3:0] nx
  );
    logic [FFLAG_W-1:0] f;
    f           = '0;
    f[FFLAG_NV] = |nv;
    f[FFLAG_DZ] = |dz;
    f[FFLAG_OF] = |ov;
    f[FFLAG_UF] = |uf;
    f[FFLAG_NX] = |nx;
    return f;
  endfunction

endpackage

// File: rtl/psimd_flag_acc.sv
// Lane reduction, capture register and fflags update for the PSIMD issue controller.
// PSIMD_ISSUE_STICKY_FFLAGS_EN selects accumulating flags with clear; otherwise each WB overwrites.
module psimd_flag_acc
  import psimd_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               capture,
  input  logic               commit,
  input  logic               clr,
  input  logic [3:0]         invalid,
  input  logic [3:0]         inexact,
  input  logic [3:0]         overflow,
  input  logic [3:0]         underflow,
  input  logic [3:0]         div_by_zero,
  output logic [FFLAG_W-1:0] fflags
);

  logic [FFLAG_W-1:0] cap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q <= '0;
    end else if (capture) begin
      cap_q <= lane_reduce(invalid, div_by_zero, overflow, underflow, inexact);
    end
  end

`ifdef PSIMD_ISSUE_STICKY_FFLAGS_EN
  // A clear coincident with write-back still keeps the flags of the retiring op.
  always_ff @(posedge clk) begin
    if (rst) begin
      fflags <= '0;
    end else if (commit) begin
      fflags <= (clr ? '0 : fflags) | cap_q;
    end else if (clr) begin
      fflags <= '0;
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      fflags <= '0;
    end else if (commit) begin
      fflags <= cap_q;
    end
  end
`endif

endmodule

// File: rtl/psimd_issue_ctrl.sv
// Issue sequencer for the PSIMD DLFloat16 unit: accept, read, execute, wait, write back.
// Flag behaviour depends on PSIMD_ISSUE_STICKY_FFLAGS_EN (handled in psimd_flag_acc).
module psimd_issue_ctrl
  import psimd_pkg::*;
#(
  parameter int EXEC_TIMEOUT = EXEC_TIMEOUT_DEF,
  parameter int CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [31:0]        instr,
  output logic               instr_ready,
  input  logic               dec_multi,
  input  logic               dec_wr,
  input  logic               dec_illegal,
  input  logic [4:0]         dec_rd,
  output logic [31:0]        instr_q,
  output logic               rf_rd_en,
  output logic               eu_start,
  input  logic               eu_done,
  input  logic [3:0]         invalid,
  input  logic [3:0]         inexact,
  input  logic [3:0]         overflow,
  input  logic [3:0]         underflow,
  input  logic [3:0]         div_by_zero,
  output logic               rf_wr_en,
  output logic [4:0]         rf_wr_addr,
  output logic [FFLAG_W-1:0] fflags,
  input  logic               fflags_clr,
  output logic               done,
  output logic               err_illegal,
  output logic               err_timeout,
  output issue_state_t       dbg_state
);

  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both high; instr_ready is high only in IDLE and the core
  // holds instr stable until the transfer.

  issue_state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             multi_q, wr_q;
  logic [4:0]       rd_q;
  logic             capture, commit, timeout_hit;

  assign dbg_state   = state;
  assign timeout_hit = (cnt == CNT_W'(EXEC_TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      instr_q <= '0;
      multi_q <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && instr_valid) begin
        instr_q <= instr;
      end
      if (state == READ && !dec_illegal) begin
        multi_q <= dec_multi;
        wr_q    <= dec_wr;
        rd_q    <= dec_rd;
      end
      if (state == EXEC) begin
        cnt <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    rf_rd_en    = 1'b0;
    eu_start    = 1'b0;
    rf_wr_en    = 1'b0;
    rf_wr_addr  = '0;
    done        = 1'b0;
    err_illegal = 1'b0;
    err_timeout = 1'b0;
    capture     = 1'b0;
    commit      = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = READ;
      end
      READ: begin
        if (dec_illegal) begin
          err_illegal = 1'b1;
          state_nxt   = IDLE;
        end else begin
          rf_rd_en  = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        eu_start = 1'b1;
        if (multi_q) begin
          state_nxt = WAIT;
        end else begin
          capture   = 1'b1;
          state_nxt = WB;
        end
      end
      WAIT: begin
        // A result arriving in the timeout cycle is still accepted.
        if (eu_done) begin
          capture   = 1'b1;
          state_nxt = WB;
        end else if (timeout_hit) begin
          err_timeout = 1'b1;
          state_nxt   = IDLE;
        end
      end
      WB: begin
        rf_wr_en   = wr_q;
        rf_wr_addr = rd_q;
        done       = 1'b1;
        commit     = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  psimd_flag_acc u_flag_acc (
    .clk         (clk),
    .rst         (rst),
    .capture     (capture),
    .commit      (commit),
    .clr         (fflags_clr),
    .invalid     (invalid),
    .inexact     (inexact),
    .overflow    (overflow),
    .underflow   (underflow),
    .div_by_zero (div_by_zero),
    .fflags      (fflags)
  );

endmodule

// File: tb/tb_psimd_issue_ctrl.sv
// Self-checking bench for psimd_issue_ctrl: directed vector table, reset-in-WAIT sequence,
// and randomized ops checked cycle by cycle against a timeline/flag model (honours PSIMD_ISSUE_STICKY_FFLAGS_EN).
module tb_psimd_issue_ctrl;

  localparam int TO = 31;
`ifdef PSIMD_ISSUE_STICKY_FFLAGS_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        dec_multi, dec_wr, dec_illegal;
  logic [4:0]  dec_rd;
  logic [31:0] instr_q;
  logic        rf_rd_en, eu_start, eu_done;
  logic [3:0]  invalid, inexact, overflow, underflow, div_by_zero;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [4:0]  fflags;
  logic        fflags_clr;
  logic        done, err_illegal, err_timeout;
  psimd_pkg::issue_state_t dbg_state;

  always #5 clk = ~clk;

  psimd_issue_ctrl #(.EXEC_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .dec_multi(dec_multi), .dec_wr(dec_wr), .dec_illegal(dec_illegal), .dec_rd(dec_rd),
    .instr_q(instr_q), .rf_rd_en(rf_rd_en), .eu_start(eu_start), .eu_done(eu_done),
    .invalid(invalid), .inexact(inexact), .overflow(overflow), .underflow(underflow),
    .div_by_zero(div_by_zero), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .fflags(fflags),
    .fflags_clr(fflags_clr), .done(done), .err_illegal(err_illegal), .err_timeout(err_timeout),
    .dbg_state(dbg_state)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [4:0] model_ff;

  typedef struct {
    logic       ill, mul, wr;
    logic [4:0] rd;
    int         k;
    logic       clr;
    logic [3:0] nv, dz, ov, uf, nx;
    logic [4:0] exp_st, exp_pl;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {instr_ready, rf_rd_en, eu_start, rf_wr_en, done, err_illegal, err_timeout}
  function automatic logic [6:0] outs();
    return {instr_ready, rf_rd_en, eu_start, rf_wr_en, done, err_illegal, err_timeout};
  endfunction

  task automatic rand_flags();
    invalid     = 4'($urandom);
    inexact     = 4'($urandom);
    overflow    = 4'($urandom);
    underflow   = 4'($urandom);
    div_by_zero = 4'($urandom);
  endtask

  // Starts in an IDLE cycle (1 time unit after an edge); returns in the IDLE cycle that follows the op.
  // k: cycles from WAIT entry to eu_done (negative = never).
  task automatic run_op(input logic ill, input logic mul, input logic wr, input logic [4:0] rd,
                        input int k, input logic clr_wb, input logic [3:0] f_nv, input logic [3:0] f_dz,
                        input logic [3:0] f_ov, input logic [3:0] f_uf, input logic [3:0] f_nx,
                        input string tag);
    int         end_c, wb_c, cap_c, to_c;
    logic       has_wb;
    logic [31:0] word;
    logic [4:0] cap, old_ff, new_ff, ea;
    logic [6:0] ev;
    has_wb = !ill && (!mul || (k >= 0 && k <= TO));
    to_c   = (mul && !ill && !has_wb) ? 3 + TO : -1;
    cap_c  = ill ? -1 : (!mul ? 2 : (has_wb ? 3 + k : -1));
    wb_c   = has_wb ? cap_c + 1 : -1;
    end_c  = ill ? 2 : (has_wb ? wb_c + 1 : to_c + 1);
    cap    = {(f_nv != 0), (f_dz != 0), (f_ov != 0), (f_uf != 0), (f_nx != 0)};
    old_ff = model_ff;
    if (has_wb) new_ff = STICKY ? ((clr_wb ? 5'd0 : old_ff) | cap) : cap;
    else        new_ff = old_ff;

    word        = $urandom;
    instr       = word;
    instr_valid = 1'b1;
    dec_illegal = ill;
    dec_multi   = mul;
    dec_wr      = wr;
    dec_rd      = rd;
    eu_done     = 1'($urandom_range(0, 1));
    fflags_clr  = 1'b0;
    rand_flags();
    #1;
    check({tag, " c0 outs"}, 32'(outs()), 32'(7'b1000000));
    check({tag, " c0 fflags"}, 32'(fflags), 32'(old_ff));
    @(posedge clk); #1;

    for (int c = 1; c <= end_c; c++) begin
      instr_valid = (c == end_c) ? 1'b0 : 1'($urandom_range(0, 1));
      instr       = $urandom;
      if (mul && k >= 0 && c == 3 + k) eu_done = 1'b1;
      else if (c < 3 || c == end_c)    eu_done = 1'($urandom_range(0, 1));
      else                             eu_done = 1'b0;
      if (c == cap_c) begin
        invalid = f_nv; div_by_zero = f_dz; overflow = f_ov; underflow = f_uf; inexact = f_nx;
      end else begin
        rand_flags();
      end
      fflags_clr = (c == wb_c) ? clr_wb : 1'b0;
      #1;
      ev = {c == end_c, c == 1 && !ill, c == 2 && !ill, c == wb_c && wr, c == wb_c, c == 1 && ill, c == to_c};
      ea = (c == wb_c) ? rd : 5'd0;
      check($sformatf("%s c%0d outs", tag, c), 32'(outs()), 32'(ev));
      check($sformatf("%s c%0d wr_addr", tag, c), 32'(rf_wr_addr), 32'(ea));
      check($sformatf("%s c%0d fflags", tag, c), 32'(fflags), 32'((c == end_c) ? new_ff : old_ff));
      if (c == 1) check({tag, " instr_q"}, instr_q, word);
      if (c < end_c) begin
        @(posedge clk); #1;
      end
    end
    fflags_clr = 1'b0;
    model_ff   = new_ff;
  endtask

  task automatic idle(input int n, input logic allow_clr);
    for (int i = 0; i < n; i++) begin
      instr_valid = 1'b0;
      eu_done     = 1'($urandom_range(0, 1));
      fflags_clr  = allow_clr ? ($urandom_range(0, 3) == 0) : 1'b0;
      rand_flags();
      #1;
      check("idle outs", 32'(outs()), 32'(7'b1000000));
      check("idle fflags", 32'(fflags), 32'(model_ff));
      if (STICKY && fflags_clr) model_ff = 5'd0;
      @(posedge clk); #1;
    end
    fflags_clr = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 5'd7,  0,  1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'b00000, 5'b00000};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 5'd3,  6,  1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 5'b00001, 5'b00001};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 5'd4,  -1, 1'b0, 4'hf, 4'hf, 4'hf, 4'hf, 4'hf, 5'b00001, 5'b00001};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 5'd5,  0,  1'b0, 4'hf, 4'h0, 4'h0, 4'h0, 4'h0, 5'b00001, 5'b00001};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 5'd10, 0,  1'b0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 5'b00101, 5'b00100};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 5'd11, 0,  1'b1, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 5'b10000, 5'b10000};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 5'd12, 0,  1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 5'b10001, 5'b00001};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 5'd13, 0,  1'b0, 4'h0, 4'hf, 4'h0, 4'h0, 4'h0, 5'b11001, 5'b01000};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 5'd14, 31, 1'b0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 5'b11011, 5'b00010};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 5'd15, 32, 1'b0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 5'b11011, 5'b00010};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 5'd16, 2,  1'b0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 5'b11011, 5'b00010};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 5'd31, 0,  1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'b00000, 5'b00000};

    rst = 1'b1; instr_valid = 1'b0; instr = '0; dec_multi = 1'b0; dec_wr = 1'b0;
    dec_illegal = 1'b0; dec_rd = '0; eu_done = 1'b0; fflags_clr = 1'b0;
    invalid = '0; inexact = '0; overflow = '0; underflow = '0; div_by_zero = '0;
    model_ff = 5'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset outs", 32'(outs()), 32'(7'b1000000));
    check("reset wr_addr", 32'(rf_wr_addr), 32'd0);
    check("reset fflags", 32'(fflags), 32'd0);
    check("reset instr_q", instr_q, 32'd0);

    // Directed table, issued back to back.
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].ill, vecs[i].mul, vecs[i].wr, vecs[i].rd, vecs[i].k, vecs[i].clr,
             vecs[i].nv, vecs[i].dz, vecs[i].ov, vecs[i].uf, vecs[i].nx, $sformatf("vec%0d", i));
      check($sformatf("vec%0d table fflags", i), 32'(fflags), 32'(STICKY ? vecs[i].exp_st : vecs[i].exp_pl));
    end

    // Set a flag so the reset below has something to clear.
    run_op(1'b0, 1'b0, 1'b1, 5'd2, 0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, "pre_rst");

    // Reset while waiting on a multi-cycle op.
    instr = 32'hdeadbeef; instr_valid = 1'b1; dec_illegal = 1'b0; dec_multi = 1'b1;
    dec_wr = 1'b1; dec_rd = 5'd9; eu_done = 1'b0; fflags_clr = 1'b0;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("wait outs", 32'(outs()), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_wait outs", 32'(outs()), 32'(7'b1000000));
    check("rst_wait wr_addr", 32'(rf_wr_addr), 32'd0);
    check("rst_wait fflags", 32'(fflags), 32'd0);
    check("rst_wait instr_q", instr_q, 32'd0);
    model_ff = 5'd0;
    eu_done  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("late_done%0d outs", i), 32'(outs()), 32'(7'b1000000));
      check($sformatf("late_done%0d fflags", i), 32'(fflags), 32'd0);
    end
    eu_done = 1'b0;

    // Randomized ops with random gaps and clears.
    for (int n = 0; n < 40; n++) begin
      logic       r_ill, r_mul, r_wr, r_clr;
      logic [4:0] r_rd;
      int         r_k, sel;
      r_ill = ($urandom_range(0, 7) == 0);
      r_mul = 1'($urandom_range(0, 1));
      r_wr  = 1'($urandom_range(0, 1));
      r_rd  = 5'($urandom);
      r_clr = ($urandom_range(0, 3) == 0);
      sel   = int'($urandom_range(0, 9));
      if (sel < 7)      r_k = int'($urandom_range(0, 8));
      else if (sel < 9) r_k = int'($urandom_range(28, 34));
      else              r_k = -1;
      run_op(r_ill, r_mul, r_wr, r_rd, r_k, r_clr,
             4'($urandom & $urandom), 4'($urandom & $urandom), 4'($urandom & $urandom),
             4'($urandom & $urandom), 4'($urandom & $urandom), $sformatf("rnd%0d", n));
      idle(int'($urandom_range(0, 3)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
